// File: rtl/dp_control_unit.sv
// Fetch/decode/execute controller for the 8-bit datapath: sequences a synchronous
// instruction ROM and drives register selects, ALU op, write-back source and handshakes.
module dp_control_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [11:0]     imem_data,
  output logic [2:0]      Rx,
  output logic [2:0]      Ry,
  output logic [2:0]      selOp,
  output logic [1:0]      destSrc,
  output logic            regWrite,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    WAIT_IN  = 3'd3,
    WAIT_OUT = 3'd4,
    HALT     = 3'd5
  } stateT;

  localparam logic [3:0] OP_IN   = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'h7;

  stateT           state, stateNext;
  logic [PC_W-1:0] pc, pcNext, pcInc;
  logic [11:0]     ir;
  logic [3:0]      opcode;
  logic            writesInExec;

  // JMP target is an 8-bit field; zero-extend or truncate to the PC width.
  function automatic logic [PC_W-1:0] jmpTarget(input logic [7:0] field);
    logic [PC_W+7:0] ext;
    ext = {{PC_W{1'b0}}, field};
    return ext[PC_W-1:0];
  endfunction

  function automatic logic [1:0] decodeDestSrc(input logic [3:0] op);
    if (op[3])            return 2'b10;
    else if (op == OP_IN) return 2'b00;
    else                  return 2'b01;
  endfunction

  function automatic logic [2:0] decodeSelOp(input logic [3:0] op);
    return op[3] ? op[2:0] : 3'd0;
  endfunction

  assign imem_addr    = pc;
  assign pcInc        = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign opcode       = ir[11:8];
  assign writesInExec = opcode[3] || (opcode == OP_MOV);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      Rx      <= 3'd0;
      Ry      <= 3'd0;
      selOp   <= 3'd0;
      destSrc <= 2'b01;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (state == DECODE) begin
        Rx      <= imem_data[7:5];
        Ry      <= imem_data[4:2];
        selOp   <= decodeSelOp(imem_data[11:8]);
        destSrc <= decodeDestSrc(imem_data[11:8]);
      end
    end
  end

  // Instruction register carries data only; it is always loaded before EXEC reads it.
  always_ff @(posedge clock) begin
    if (state == DECODE) ir <= imem_data;
  end

  // Writes are masked by reset so an abandoned handshake never touches the register file.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    regWrite  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (state)
      FETCH:  stateNext = DECODE;
      DECODE: stateNext = EXEC;
      EXEC: begin
        case (opcode)
          OP_IN:   stateNext = WAIT_IN;
          OP_OUT:  stateNext = WAIT_OUT;
          OP_HALT: stateNext = HALT;
          OP_JMP: begin
            pcNext    = jmpTarget(ir[7:0]);
            stateNext = FETCH;
          end
          default: begin
            regWrite  = writesInExec && !reset;
            pcNext    = pcInc;
            stateNext = FETCH;
          end
        endcase
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          regWrite  = !reset;
          pcNext    = pcInc;
          stateNext = FETCH;
        end
      end
      WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pcNext    = pcInc;
          stateNext = FETCH;
        end
      end
      HALT:    halted = 1'b1;
      default: stateNext = FETCH;
    endcase
  end

endmodule

// File: tb/tb_dp_control_unit.sv
// Directed bench for dp_control_unit: an 8-bit-PC instance running a small IN/ADD/OUT/HALT
// program against a datapath model, and a 4-bit-PC instance exercising JMP truncation and wrap.
module tb_dp_control_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic [7:0]  addr8;
  logic [11:0] data8;
  logic [2:0]  rx8, ry8, sel8;
  logic [1:0]  dst8;
  logic        wr8, inValid8, inReady8, outValid8, outReady8, halt8;

  logic [3:0]  addr4;
  logic [11:0] data4;
  logic [2:0]  rx4, ry4, sel4;
  logic [1:0]  dst4;
  logic        wr4, inValid4, inReady4, outValid4, outReady4, halt4;

  logic [11:0] rom8 [256];
  logic [11:0] rom4 [16];

  logic [7:0] regs [8];
  logic [7:0] dataIn, aluOut, wbVal;
  int         wrCount = 0;

  int checks = 0;
  int errors = 0;

  dp_control_unit #(.PC_W(8), .RESET_PC(8'h10)) dut8 (
    .clock(clock), .reset(reset), .imem_addr(addr8), .imem_data(data8),
    .Rx(rx8), .Ry(ry8), .selOp(sel8), .destSrc(dst8), .regWrite(wr8),
    .in_valid(inValid8), .in_ready(inReady8), .out_valid(outValid8),
    .out_ready(outReady8), .halted(halt8)
  );

  dp_control_unit #(.PC_W(4)) dut4 (
    .clock(clock), .reset(reset), .imem_addr(addr4), .imem_data(data4),
    .Rx(rx4), .Ry(ry4), .selOp(sel4), .destSrc(dst4), .regWrite(wr4),
    .in_valid(inValid4), .in_ready(inReady4), .out_valid(outValid4),
    .out_ready(outReady4), .halted(halt4)
  );

  // Synchronous ROMs and the datapath the controller steers.
  always @(posedge clock) begin
    data8 <= rom8[addr8];
    data4 <= rom4[addr4];
  end

  always_comb begin
    case (sel8)
      3'd0:    aluOut = regs[ry8] + regs[rx8];
      3'd1:    aluOut = regs[ry8] - regs[rx8];
      3'd2:    aluOut = regs[ry8] & regs[rx8];
      3'd3:    aluOut = regs[ry8] | regs[rx8];
      default: aluOut = regs[ry8] ^ regs[rx8];
    endcase
    case (dst8)
      2'b00:   wbVal = dataIn;
      2'b01:   wbVal = regs[ry8];
      2'b10:   wbVal = aluOut;
      default: wbVal = regs[rx8];
    endcase
  end

  always @(posedge clock) begin
    if (wr8) begin
      regs[rx8] <= wbVal;
      wrCount   <= wrCount + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom8[i] = 12'h000;
    for (int i = 0; i < 16; i++)  rom4[i] = 12'h000;
    rom8[8'h10] = 12'h120;  // IN R1
    rom8[8'h11] = 12'h140;  // IN R2
    rom8[8'h12] = 12'h828;  // ADD R1,R2
    rom8[8'h13] = 12'h404;  // OUT R1
    rom8[8'h14] = 12'h700;  // HALT
    rom4[2]     = 12'h51F;  // JMP 0x1F

    reset = 1'b1;
    inValid8 = 1'b0; outReady8 = 1'b0;
    inValid4 = 1'b0; outReady4 = 1'b0;
    dataIn = 8'h00;
    tick();
    tick();

    check("rst_addr",     addr8,     8'h10);
    check("rst_rx",       rx8,       3'd0);
    check("rst_ry",       ry8,       3'd0);
    check("rst_selop",    sel8,      3'd0);
    check("rst_destsrc",  dst8,      2'b01);
    check("rst_regwrite", wr8,       1'b0);
    check("rst_inready",  inReady8,  1'b0);
    check("rst_outvalid", outValid8, 1'b0);
    check("rst_halted",   halt8,     1'b0);

    reset = 1'b0;
    check("pc4_c0", addr4, 4'h0);
    tick();
    tick();
    check("in1_exec_rx",  rx8, 3'd1);
    check("in1_exec_dst", dst8, 2'b00);
    check("in1_exec_wr",  wr8, 1'b0);

    for (int c = 3; c <= 22; c++) begin
      tick();
      check("stall_inready", inReady8, 1'b1);
      check("stall_wr",      wr8, 1'b0);
      check("stall_pc",      addr8, 8'h10);
      if (c == 9)  check("pc4_jmp_trunc", addr4, 4'hF);
      if (c == 12) check("pc4_wrap",      addr4, 4'h0);
      if (c == 12) check("pc4_nowrite",   wr4, 1'b0);
    end

    tick();
    inValid8 = 1'b1;
    dataIn = 8'h05;
    #1;
    check("in1_hs_wr",  wr8, 1'b1);
    check("in1_hs_dst", dst8, 2'b00);
    tick();
    inValid8 = 1'b0;
    check("in1_next_pc",  addr8, 8'h11);
    check("in1_next_rdy", inReady8, 1'b0);
    check("in1_next_wr",  wr8, 1'b0);
    check("r1_is_5",      regs[1], 8'h05);

    tick();
    tick();
    check("in2_exec_rx", rx8, 3'd2);
    tick();
    check("in2_wait_rdy", inReady8, 1'b1);
    inValid8 = 1'b1;
    dataIn = 8'h03;
    #1;
    check("in2_hs_wr", wr8, 1'b1);
    tick();
    inValid8 = 1'b0;
    check("in2_next_pc", addr8, 8'h12);
    check("r2_is_3",     regs[2], 8'h03);

    tick();
    tick();
    check("add_wr",  wr8, 1'b1);
    check("add_dst", dst8, 2'b10);
    check("add_sel", sel8, 3'd0);
    check("add_rx",  rx8, 3'd1);
    check("add_ry",  ry8, 3'd2);
    tick();
    check("add_next_wr", wr8, 1'b0);
    check("add_next_pc", addr8, 8'h13);
    check("r1_is_8",     regs[1], 8'h08);

    tick();
    tick();
    check("out_exec_wr",  wr8, 1'b0);
    check("out_exec_ry",  ry8, 3'd1);
    check("out_exec_vld", outValid8, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("ostall_valid",   outValid8, 1'b1);
      check("ostall_ry",      ry8, 3'd1);
      check("ostall_wr",      wr8, 1'b0);
      check("ostall_dataout", regs[ry8], 8'h08);
    end
    outReady8 = 1'b1;
    #1;
    check("out_hs_valid", outValid8, 1'b1);
    tick();
    outReady8 = 1'b0;
    check("out_drop_valid", outValid8, 1'b0);
    check("out_next_pc",    addr8, 8'h14);

    tick();
    tick();
    check("halt_exec_halted", halt8, 1'b0);
    tick();
    inValid8 = 1'b1;
    outReady8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("halt_halted",   halt8, 1'b1);
      check("halt_wr",       wr8, 1'b0);
      check("halt_inready",  inReady8, 1'b0);
      check("halt_outvalid", outValid8, 1'b0);
      check("halt_pc",       addr8, 8'h14);
      tick();
    end
    inValid8 = 1'b0;
    outReady8 = 1'b0;
    check("write_count", wrCount, 3);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rerst_halted", halt8, 1'b0);
    tick();
    tick();
    tick();
    check("rerst_wait_rdy", inReady8, 1'b1);
    inValid8 = 1'b1;
    dataIn = 8'h55;
    reset = 1'b1;
    #1;
    check("rst_vs_in_wr", wr8, 1'b0);
    tick();
    reset = 1'b0;
    inValid8 = 1'b0;
    check("rst_in_pc",      addr8, 8'h10);
    check("rst_in_rdy",     inReady8, 1'b0);
    check("rst_in_wr",      wr8, 1'b0);
    check("rst_in_r1_kept", regs[1], 8'h08);
    check("rst_in_count",   wrCount, 3);
    tick();
    tick();
    tick();
    check("resume_wait_rdy", inReady8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_control_unit.md
Name: dp_control_unit

Overview:
- Multi-cycle fetch/decode/execute controller sitting directly upstream of the 8-bit datapath (register file + ALU + write-back mux).
- Fetches 12-bit instructions from a synchronous instruction ROM and drives the datapath's Rx, Ry, selOp, destSrc and regWrite.
- Handles the external input handshake (IN), output handshake (OUT), jumps and halt.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
imem_addr  output  PC_W  instruction ROM address; equals pc
imem_data  input  12  ROM read data, valid one cycle after imem_addr
Rx  output  3  datapath write/operand-B register select
Ry  output  3  datapath operand-A register select
selOp  output  3  ALU operation select
destSrc  output  2  write-back mux select: 00 dataIn, 01 dataA (Ry), 10 ALU result, 11 dataB (Rx)
regWrite  output  1  register file write enable
in_valid  input  1  external dataIn holds valid byte
in_ready  output  1  controller accepting dataIn
out_valid  output  1  datapath dataOut holds Ry value for consumer
out_ready  input  1  consumer accepts dataOut
halted  output  1  HALT executed; controller idle

Behaviour:
- Instruction format: [11:8] opcode, [7:5] Rx, [4:2] Ry, [1:0] unused; JMP uses [7:0] as target.
- Opcodes:
  - 0x0 NOP.
  - 0x1 IN Rx: destSrc=00; Rx <- dataIn.
  - 0x2 MOV Rx,Ry: destSrc=01.
  - 0x4 OUT Ry: destSrc=01, no write.
  - 0x5 JMP: target zero-extended/truncated to PC_W.
  - 0x7 HALT.
  - 0x8–0xF ALU Rx,Ry: selOp=opcode[2:0], destSrc=10.
  - 0x3, 0x6: treated as NOP.
- States:
  - FETCH -> DECODE -> EXEC -> FETCH (3 cycles per plain instruction).
  - WAIT_IN, WAIT_OUT (variable length).
  - HALT (terminal until reset).
- FETCH: imem_addr=pc; no control outputs active.
- DECODE: IR <- imem_data. Rx/Ry/selOp/destSrc registered from IR on the DECODE->EXEC edge; they hold stable until the next DECODE.
- EXEC:
  - MOV/ALU: regWrite=1 for exactly this one cycle; pc <- pc+1; -> FETCH.
  - NOP: pc <- pc+1; -> FETCH.
  - JMP: pc <- target; -> FETCH.
  - IN: -> WAIT_IN.
  - OUT: -> WAIT_OUT.
  - HALT: -> HALT, pc unchanged.
- WAIT_IN:
  - in_ready=1.
  - regWrite = in_valid (combinational), so the write happens in the same cycle as the handshake.
  - On in_valid: pc+1, -> FETCH. Otherwise stay, regWrite=0.
- WAIT_OUT:
  - out_valid=1.
  - On out_ready: pc+1, -> FETCH.
  - Never writes the register file.
- HALT: halted=1; all handshake outputs 0; regWrite=0; ignores in_valid/out_ready.
- regWrite is never high outside EXEC (MOV/ALU) or the WAIT_IN handshake cycle. At most one write per instruction.
- pc increments modulo 2^PC_W (all-ones wraps to 0).
- Reset values:
  - state=FETCH, pc=RESET_PC.
  - Rx=Ry=selOp=0, destSrc=01.
  - regWrite=in_ready=out_valid=halted=0.
- Reset mid-operation: any pending IN/OUT handshake is abandoned with no register write; reset wins over a simultaneous in_valid/out_ready.
- in_valid and out_ready asserted outside their wait states have no effect.

Test Plan:
- Reset with RESET_PC=0x10 -> imem_addr=0x10 next cycle; all control outputs at their reset values; halted=0.
- ROM: IN R1, IN R2, ADD(op 0x8) R1,R2, OUT R1, HALT.
  - Feed 0x05, then 0x03 (in_valid high for one cycle each).
  - Required: regWrite pulses once per instruction with destSrc 00, 00, 10.
  - out_valid rises with Ry=1 and dataOut=0x08.
  - halted=1 after 0x0E-ish cycles; pc stays at the HALT address.
- Input stall: hold in_valid=0 for 20 cycles during IN.
  - Required: in_ready stays 1, regWrite stays 0, pc frozen.
  - in_valid=1 for one cycle -> exactly one regWrite, then FETCH.
- Output stall: out_ready=0 for 10 cycles during OUT.
  - Required: out_valid held 1, Ry stable, no regWrite.
  - out_ready=1 -> out_valid drops the next cycle.
- PC_W=4:
  - JMP 0x1F at addr 2 -> next fetch at 0xF.
  - NOP at 0xF -> next fetch at 0x0 (wrap).
- Assert reset during WAIT_IN with in_valid=1 in the same cycle -> no regWrite; state=FETCH, pc=RESET_PC next cycle.
